tl_tx_scheduler: RTL and testbench

//  Parametrised TL transmit scheduler between Tx P/NP/CPL header+data FIFOs and the DLL TLP interface.

---
 rtl/tl_pkg.sv | 35 +++
 rtl/tl_credit_gate.sv | 39 +++
 rtl/tl_tx_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_tl_tx_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and helpers for the TL transmit path: request codes, traffic classes, credit window test.
package tl_pkg;

  typedef enum logic [2:0] {
    REQ_IDLE     = 3'd0,
    REQ_P_HDR    = 3'd1,
    REQ_P_DATA   = 3'd2,
    REQ_NP_HDR   = 3'd3,
    REQ_CPL_HDR  = 3'd5,
    REQ_CPL_DATA = 3'd6
  } req_t;

  typedef enum logic [1:0] {
    CLS_P   = 2'd0,
    CLS_NP  = 2'd1,
    CLS_CPL = 2'd2
  } tl_class_t;

  localparam int LEN_W = 11;

  // Window test in modulo-2^cw space: the send fits if it stays within half the counter range of the limit.
  function automatic logic credit_ok(input logic [31:0] limit, input logic [31:0] consumed,
                                     input logic [31:0] need, input int cw);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    diff = (limit - (consumed + need)) & mask;
    return diff <= (32'd1 << (cw - 1));
  endfunction

  function automatic logic [LEN_W-1:0] len_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/tl_credit_gate.sv
// One credit type: holds the DLL limit and the consumed count; ok is combinational for the offered need.
// Latency: limit and consumed update one cycle after cl_en/commit; no backpressure of its own.
module tl_credit_gate
  import tl_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cl_en,
  input  logic [CW-1:0] cl_limit,
  input  logic [CW-1:0] need,
  input  logic          commit,
  output logic          ok,
  output logic [CW-1:0] consumed
);

  logic [CW-1:0] limit;
  logic          loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit    <= '0;
      loaded   <= 1'b0;
      consumed <= '0;
    end else begin
      if (cl_en) begin
        limit  <= cl_limit;
        loaded <= 1'b1;
      end
      if (commit) consumed <= consumed + need;
    end
  end

  // A loaded limit of zero advertises infinite credit.
  assign ok = (loaded && (limit == '0)) ||
              credit_ok(32'(limit), 32'(consumed), 32'(need), CW);

endmodule

// File: rtl/tl_tx_scheduler.sv
// Weighted round-robin P/NP/CPL transmit scheduler with credit and retry-space gating; emits header then beats.
// Latency: grant->header 1 cycle, 1 idle cycle before first beat; data FIFO empty stalls with req IDLE.
module tl_tx_scheduler
  import tl_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int HDR_WIDTH       = 128,
  parameter int CREDIT_WIDTH    = 12,
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int W_P             = 2,
  parameter int W_NP            = 1,
  parameter int W_CPL           = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         p_hdr_empty_i,
  input  logic [HDR_WIDTH-1:0]         p_hdr_rdata_i,
  output logic                         p_hdr_rden_o,
  input  logic                         np_hdr_empty_i,
  input  logic [HDR_WIDTH-1:0]         np_hdr_rdata_i,
  output logic                         np_hdr_rden_o,
  input  logic                         cpl_hdr_empty_i,
  input  logic [HDR_WIDTH-1:0]         cpl_hdr_rdata_i,
  output logic                         cpl_hdr_rden_o,
  input  logic                         p_data_empty_i,
  input  logic [DATA_WIDTH-1:0]        p_data_rdata_i,
  output logic                         p_data_rden_o,
  input  logic                         cpl_data_empty_i,
  input  logic [DATA_WIDTH-1:0]        cpl_data_rdata_i,
  output logic                         cpl_data_rden_o,
  output logic                         p_sent_o,
  output logic                         cpl_sent_o,
  input  logic [CREDIT_WIDTH-1:0]      cl_ph_i,
  input  logic [CREDIT_WIDTH-1:0]      cl_pd_i,
  input  logic [CREDIT_WIDTH-1:0]      cl_nh_i,
  input  logic [CREDIT_WIDTH-1:0]      cl_ch_i,
  input  logic [CREDIT_WIDTH-1:0]      cl_cd_i,
  input  logic                         cl_en_i,
  output logic [CREDIT_WIDTH-1:0]      tx_cc_ph_o,
  output logic [CREDIT_WIDTH-1:0]      tx_cc_pd_o,
  output logic [CREDIT_WIDTH-1:0]      tx_cc_nh_o,
  output logic [CREDIT_WIDTH-1:0]      tx_cc_ch_o,
  output logic [CREDIT_WIDTH-1:0]      tx_cc_cd_o,
  input  logic [RETRY_DEPTH_LG2+2:0]   retry_leftover_i,
  input  logic                         link_active_i,
  output logic [DATA_WIDTH-1:0]        tlp_o,
  output req_t                         req_o
);

  localparam int DPB = DATA_WIDTH / 32;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} st_t;

  st_t                    state, state_nxt;
  tl_class_t              cur, cur_nxt, gnt_cls;
  logic [2:0]             wcnt, wcnt_nxt;
  logic [LEN_W-1:0]       beats_q, beats_nxt;
  logic [DATA_WIDTH-1:0]  tlp_q, tlp_nxt;
  req_t                   req_q, req_nxt;
  logic                   p_sent_q, p_sent_nxt, cpl_sent_q, cpl_sent_nxt;
  logic                   grant, rotate, data_pop;
  logic [2:0]             elig;

  logic [LEN_W-1:0]        p_len, cpl_len, p_beats, cpl_beats;
  logic [CREDIT_WIDTH-1:0] p_dcred, cpl_dcred;
  logic                    ph_ok, pd_ok, nh_ok, ch_ok, cd_ok;
  logic                    p_rok, np_rok, cpl_rok;
  logic                    commit_p, commit_np, commit_cpl;

  assign p_len     = len_dw(p_hdr_rdata_i[9:0]);
  assign cpl_len   = len_dw(cpl_hdr_rdata_i[9:0]);
  assign p_dcred   = CREDIT_WIDTH'((p_len + 11'd3) >> 2);
  assign cpl_dcred = CREDIT_WIDTH'((cpl_len + 11'd3) >> 2);
  assign p_beats   = LEN_W'((32'(p_len) + DPB - 1) / DPB);
  assign cpl_beats = LEN_W'((32'(cpl_len) + DPB - 1) / DPB);
  assign p_rok     = (32'(p_len) + 32'd4) <= 32'(retry_leftover_i);
  assign np_rok    = 32'd4 <= 32'(retry_leftover_i);
  assign cpl_rok   = (32'(cpl_len) + 32'd3) <= 32'(retry_leftover_i);

  assign commit_p   = grant && (gnt_cls == CLS_P);
  assign commit_np  = grant && (gnt_cls == CLS_NP);
  assign commit_cpl = grant && (gnt_cls == CLS_CPL);

  tl_credit_gate #(.CW(CREDIT_WIDTH)) u_ph (.clk(clk), .rst_n(rst_n), .cl_en(cl_en_i), .cl_limit(cl_ph_i),
    .need(CREDIT_WIDTH'(1)), .commit(commit_p), .ok(ph_ok), .consumed(tx_cc_ph_o));
  tl_credit_gate #(.CW(CREDIT_WIDTH)) u_pd (.clk(clk), .rst_n(rst_n), .cl_en(cl_en_i), .cl_limit(cl_pd_i),
    .need(p_dcred), .commit(commit_p), .ok(pd_ok), .consumed(tx_cc_pd_o));
  tl_credit_gate #(.CW(CREDIT_WIDTH)) u_nh (.clk(clk), .rst_n(rst_n), .cl_en(cl_en_i), .cl_limit(cl_nh_i),
    .need(CREDIT_WIDTH'(1)), .commit(commit_np), .ok(nh_ok), .consumed(tx_cc_nh_o));
  tl_credit_gate #(.CW(CREDIT_WIDTH)) u_ch (.clk(clk), .rst_n(rst_n), .cl_en(cl_en_i), .cl_limit(cl_ch_i),
    .need(CREDIT_WIDTH'(1)), .commit(commit_cpl), .ok(ch_ok), .consumed(tx_cc_ch_o));
  tl_credit_gate #(.CW(CREDIT_WIDTH)) u_cd (.clk(clk), .rst_n(rst_n), .cl_en(cl_en_i), .cl_limit(cl_cd_i),
    .need(cpl_dcred), .commit(commit_cpl), .ok(cd_ok), .consumed(tx_cc_cd_o));

  assign elig[0] = !p_hdr_empty_i   && link_active_i && ph_ok && pd_ok && p_rok;
  assign elig[1] = !np_hdr_empty_i  && link_active_i && nh_ok && np_rok;
  assign elig[2] = !cpl_hdr_empty_i && link_active_i && ch_ok && cd_ok && cpl_rok;

  function automatic logic pick(input logic [2:0] e, input tl_class_t c);
    case (c)
      CLS_P:   return e[0];
      CLS_NP:  return e[1];
      default: return e[2];
    endcase
  endfunction

  function automatic int weight(input tl_class_t c);
    case (c)
      CLS_P:   return W_P;
      CLS_NP:  return W_NP;
      default: return W_CPL;
    endcase
  endfunction

  function automatic tl_class_t rot_cls(input tl_class_t c, input int k);
    int idx;
    idx = (int'(c) + k) % 3;
    return tl_class_t'(idx[1:0]);
  endfunction

  // Stay on the current class until its weight is spent; the current class is tried last when rotating.
  always_comb begin
    grant   = 1'b0;
    rotate  = 1'b0;
    gnt_cls = cur;
    if (state == ST_IDLE) begin
      if (pick(elig, cur) && (int'(wcnt) < weight(cur))) begin
        grant = 1'b1;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          if (!grant && pick(elig, rot_cls(cur, k))) begin
            grant   = 1'b1;
            rotate  = 1'b1;
            gnt_cls = rot_cls(cur, k);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    wcnt_nxt     = wcnt;
    beats_nxt    = beats_q;
    tlp_nxt      = '0;
    req_nxt      = REQ_IDLE;
    p_sent_nxt   = 1'b0;
    cpl_sent_nxt = 1'b0;
    data_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          state_nxt = ST_HDR;
          cur_nxt   = gnt_cls;
          wcnt_nxt  = rotate ? 3'd0 : wcnt;
          case (gnt_cls)
            CLS_P: begin
              tlp_nxt    = DATA_WIDTH'(p_hdr_rdata_i);
              req_nxt    = REQ_P_HDR;
              beats_nxt  = p_beats;
              p_sent_nxt = (p_beats == '0);
            end
            CLS_NP: begin
              tlp_nxt   = DATA_WIDTH'(np_hdr_rdata_i);
              req_nxt   = REQ_NP_HDR;
              beats_nxt = '0;
            end
            default: begin
              tlp_nxt      = DATA_WIDTH'(cpl_hdr_rdata_i);
              req_nxt      = REQ_CPL_HDR;
              beats_nxt    = cpl_beats;
              cpl_sent_nxt = (cpl_beats == '0);
            end
          endcase
        end
      end
      ST_HDR: begin
        wcnt_nxt  = wcnt + 3'd1;
        state_nxt = (beats_q != '0) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        if (!((cur == CLS_P) ? p_data_empty_i : cpl_data_empty_i)) begin
          data_pop  = 1'b1;
          tlp_nxt   = (cur == CLS_P) ? p_data_rdata_i : cpl_data_rdata_i;
          req_nxt   = (cur == CLS_P) ? REQ_P_DATA : REQ_CPL_DATA;
          beats_nxt = beats_q - 1'b1;
          if (beats_q == LEN_W'(1)) begin
            state_nxt    = ST_IDLE;
            p_sent_nxt   = (cur == CLS_P);
            cpl_sent_nxt = (cur == CLS_CPL);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= CLS_P;
      wcnt       <= '0;
      beats_q    <= '0;
      tlp_q      <= '0;
      req_q      <= REQ_IDLE;
      p_sent_q   <= 1'b0;
      cpl_sent_q <= 1'b0;
    end else begin
      cur        <= cur_nxt;
      wcnt       <= wcnt_nxt;
      beats_q    <= beats_nxt;
      tlp_q      <= tlp_nxt;
      req_q      <= req_nxt;
      p_sent_q   <= p_sent_nxt;
      cpl_sent_q <= cpl_sent_nxt;
    end
  end

  assign p_hdr_rden_o    = commit_p;
  assign np_hdr_rden_o   = commit_np;
  assign cpl_hdr_rden_o  = commit_cpl;
  assign p_data_rden_o   = data_pop && (cur == CLS_P);
  assign cpl_data_rden_o = data_pop && (cur == CLS_CPL);
  assign p_sent_o        = p_sent_q;
  assign cpl_sent_o      = cpl_sent_q;
  assign tlp_o           = tlp_q;
  assign req_o           = req_q;

endmodule

// File: tb/tb_tl_tx_scheduler.sv
// Directed bench for tl_tx_scheduler: FWFT FIFO models, output log, hand-computed expectations.
module tb_tl_tx_scheduler;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         p_hdr_empty_i, np_hdr_empty_i, cpl_hdr_empty_i;
  logic [127:0] p_hdr_rdata_i, np_hdr_rdata_i, cpl_hdr_rdata_i;
  logic         p_hdr_rden_o, np_hdr_rden_o, cpl_hdr_rden_o;
  logic         p_data_empty_i, cpl_data_empty_i;
  logic [255:0] p_data_rdata_i, cpl_data_rdata_i;
  logic         p_data_rden_o, cpl_data_rden_o, p_sent_o, cpl_sent_o;
  logic [11:0]  cl_ph_i = '0, cl_pd_i = '0, cl_nh_i = '0, cl_ch_i = '0, cl_cd_i = '0;
  logic         cl_en_i = 1'b0;
  logic [11:0]  tx_cc_ph_o, tx_cc_pd_o, tx_cc_nh_o, tx_cc_ch_o, tx_cc_cd_o;
  logic [10:0]  retry_leftover_i = 11'd2047;
  logic         link_active_i = 1'b1;
  logic [255:0] tlp_o;
  req_t         req_o;

  tl_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .p_hdr_empty_i(p_hdr_empty_i), .p_hdr_rdata_i(p_hdr_rdata_i), .p_hdr_rden_o(p_hdr_rden_o),
    .np_hdr_empty_i(np_hdr_empty_i), .np_hdr_rdata_i(np_hdr_rdata_i), .np_hdr_rden_o(np_hdr_rden_o),
    .cpl_hdr_empty_i(cpl_hdr_empty_i), .cpl_hdr_rdata_i(cpl_hdr_rdata_i), .cpl_hdr_rden_o(cpl_hdr_rden_o),
    .p_data_empty_i(p_data_empty_i), .p_data_rdata_i(p_data_rdata_i), .p_data_rden_o(p_data_rden_o),
    .cpl_data_empty_i(cpl_data_empty_i), .cpl_data_rdata_i(cpl_data_rdata_i), .cpl_data_rden_o(cpl_data_rden_o),
    .p_sent_o(p_sent_o), .cpl_sent_o(cpl_sent_o),
    .cl_ph_i(cl_ph_i), .cl_pd_i(cl_pd_i), .cl_nh_i(cl_nh_i), .cl_ch_i(cl_ch_i), .cl_cd_i(cl_cd_i),
    .cl_en_i(cl_en_i),
    .tx_cc_ph_o(tx_cc_ph_o), .tx_cc_pd_o(tx_cc_pd_o), .tx_cc_nh_o(tx_cc_nh_o),
    .tx_cc_ch_o(tx_cc_ch_o), .tx_cc_cd_o(tx_cc_cd_o),
    .retry_leftover_i(retry_leftover_i), .link_active_i(link_active_i),
    .tlp_o(tlp_o), .req_o(req_o)
  );

  // Header FIFOs: memories filled by the stimulus, heads advanced on DUT pops.
  logic [127:0] p_mem [64];
  logic [127:0] np_mem [64];
  logic [127:0] cpl_mem [64];
  logic [5:0]   p_hd = '0, p_tl = '0, np_hd = '0, np_tl = '0, cpl_hd = '0, cpl_tl = '0;
  int           p_beat = 0, c_beat = 0;
  logic         p_dstall = 1'b0, c_dstall = 1'b0;

  assign p_hdr_empty_i    = (p_hd == p_tl);
  assign np_hdr_empty_i   = (np_hd == np_tl);
  assign cpl_hdr_empty_i  = (cpl_hd == cpl_tl);
  assign p_hdr_rdata_i    = p_mem[p_hd];
  assign np_hdr_rdata_i   = np_mem[np_hd];
  assign cpl_hdr_rdata_i  = cpl_mem[cpl_hd];
  assign p_data_empty_i   = p_dstall;
  assign cpl_data_empty_i = c_dstall;
  assign p_data_rdata_i   = {224'd0, 32'hD000_0000 + 32'(p_beat)};
  assign cpl_data_rdata_i = {224'd0, 32'hC000_0000 + 32'(c_beat)};

  always @(posedge clk) begin
    if (p_hdr_rden_o)    p_hd   <= p_hd + 6'd1;
    if (np_hdr_rden_o)   np_hd  <= np_hd + 6'd1;
    if (cpl_hdr_rden_o)  cpl_hd <= cpl_hd + 6'd1;
    if (p_data_rden_o)   p_beat <= p_beat + 1;
    if (cpl_data_rden_o) c_beat <= c_beat + 1;
  end

  // Output log: {req, header tag (DW3) or beat word}.
  logic [34:0] logq[$];
  int p_sent_n = 0, c_sent_n = 0;
  always @(negedge clk) begin
    if (p_sent_o)   p_sent_n <= p_sent_n + 1;
    if (cpl_sent_o) c_sent_n <= c_sent_n + 1;
    if (req_o != REQ_IDLE)
      logq.push_back({req_o, (req_o == REQ_P_HDR || req_o == REQ_NP_HDR || req_o == REQ_CPL_HDR) ?
                             tlp_o[127:96] : tlp_o[31:0]});
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int n_req(input int s, input logic [2:0] code);
    int n = 0;
    for (int i = s; i < logq.size(); i++) if (logq[i][34:32] == code) n++;
    return n;
  endfunction

  function automatic logic [31:0] nth_word(input int s, input logic [2:0] code, input int k);
    int n = 0;
    for (int i = s; i < logq.size(); i++)
      if (logq[i][34:32] == code) begin
        if (n == k) return logq[i][31:0];
        n++;
      end
    return 32'hFFFF_FFFF;
  endfunction

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int cls, input logic [9:0] len, input logic [31:0] tag);
    logic [127:0] h;
    h = '0;
    h[127:96] = tag;
    h[9:0] = len;
    case (cls)
      0: begin p_mem[p_tl] = h; p_tl = p_tl + 6'd1; end
      1: begin np_mem[np_tl] = h; np_tl = np_tl + 6'd1; end
      default: begin cpl_mem[cpl_tl] = h; cpl_tl = cpl_tl + 6'd1; end
    endcase
  endtask

  task automatic load_limits(input logic [11:0] ph, input logic [11:0] pd);
    cl_ph_i = ph; cl_pd_i = pd; cl_nh_i = '0; cl_ch_i = '0; cl_cd_i = '0;
    cl_en_i = 1'b1;
    @(negedge clk);
    cl_en_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(1);
    load_limits(12'd0, 12'd0);
  endtask

  task automatic wait_p_pop(input string tag);
    for (int i = 0; i < 20 && !p_data_rden_o; i++) @(negedge clk);
    chk(tag, p_data_rden_o, 1'b1);
  endtask

  initial begin
    int s, ps, j, b0;
    logic [2:0] exp2 [11];
    exp2 = '{3'd1, 3'd1, 3'd3, 3'd5, 3'd5, 3'd5, 3'd5, 3'd1, 3'd1, 3'd3, 3'd5};

    // Reset values
    @(negedge clk);
    chk("rst_req", req_o, REQ_IDLE);
    chk("rst_tlp", tlp_o[63:0], 64'd0);
    chk("rst_cc_ph", tx_cc_ph_o, 12'd0);
    chk("rst_sent", {p_sent_o, cpl_sent_o}, 2'b00);
    chk("rst_rden", {p_hdr_rden_o, p_data_rden_o}, 2'b00);
    rst_n = 1'b1;
    run(1);
    load_limits(12'd0, 12'd0);

    // 1: single P write, 16 DW -> header + 2 beats
    s = logq.size(); ps = p_sent_n; b0 = p_beat;
    push(0, 10'd16, 32'h0000_0001);
    run(10);
    chk("t1_hdr", nth_word(s, REQ_P_HDR, 0), 32'h0000_0001);
    chk("t1_nbeats", n_req(s, REQ_P_DATA), 2);
    chk("t1_beat0", nth_word(s, REQ_P_DATA, 0), 32'hD000_0000 + 32'(b0));
    chk("t1_beat1", nth_word(s, REQ_P_DATA, 1), 32'hD000_0001 + 32'(b0));
    chk("t1_sent", p_sent_n - ps, 1);
    chk("t1_cc_ph", tx_cc_ph_o, 12'd1);
    chk("t1_cc_pd", tx_cc_pd_o, 12'd4);

    // 2: WRR grant order with all classes backlogged
    do_reset();
    s = logq.size(); ps = c_sent_n;
    for (int i = 0; i < 4; i++) push(0, 10'd8, 32'h20 + i);
    for (int i = 0; i < 2; i++) push(1, 10'd1, 32'h30 + i);
    for (int i = 0; i < 5; i++) push(2, 10'd4, 32'h40 + i);
    run(90);
    j = 0;
    for (int i = s; i < logq.size(); i++)
      if (logq[i][34:32] == 3'd1 || logq[i][34:32] == 3'd3 || logq[i][34:32] == 3'd5) begin
        if (j < 11) chk($sformatf("t2_grant%0d", j), logq[i][34:32], exp2[j]);
        j++;
      end
    chk("t2_ngrant", j, 11);
    chk("t2_cpl_sent", c_sent_n - ps, 5);
    chk("t2_cc_nh", tx_cc_nh_o, 12'd2);

    // 3: header credit limit of 2 holds the third P until the limit is raised
    do_reset();
    load_limits(12'd2, 12'd0);
    ps = p_sent_n;
    for (int i = 0; i < 3; i++) push(0, 10'd4, 32'h50 + i);
    run(30);
    chk("t3_sent_held", p_sent_n - ps, 2);
    chk("t3_cc_ph_held", tx_cc_ph_o, 12'd2);
    chk("t3_pending", p_hdr_empty_i, 1'b0);
    load_limits(12'd3, 12'd0);
    run(12);
    chk("t3_sent_after", p_sent_n - ps, 3);
    chk("t3_cc_ph_after", tx_cc_ph_o, 12'd3);

    // 4: retry space 10 DW blocks P(8 DW, needs 12) but lets NP through
    do_reset();
    retry_leftover_i = 11'd10;
    s = logq.size(); ps = p_sent_n;
    push(0, 10'd8, 32'h60);
    push(1, 10'd1, 32'h61);
    run(12);
    chk("t4_np_hdr", n_req(s, REQ_NP_HDR), 1);
    chk("t4_p_blocked", n_req(s, REQ_P_HDR), 0);
    retry_leftover_i = 11'd12;
    run(12);
    chk("t4_p_hdr", nth_word(s, REQ_P_HDR, 0), 32'h60);
    chk("t4_p_sent", p_sent_n - ps, 1);
    retry_leftover_i = 11'd2047;

    // 5: data FIFO runs dry between beats
    s = logq.size(); ps = p_sent_n; b0 = p_beat;
    push(0, 10'd24, 32'h70);
    wait_p_pop("t5_first_pop");
    @(posedge clk);
    #1 p_dstall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_stall_req%0d", i), req_o, REQ_IDLE);
      chk($sformatf("t5_stall_rden%0d", i), p_data_rden_o, 1'b0);
    end
    p_dstall = 1'b0;
    run(10);
    chk("t5_nbeats", n_req(s, REQ_P_DATA), 3);
    chk("t5_beat2", nth_word(s, REQ_P_DATA, 2), 32'hD000_0002 + 32'(b0));
    chk("t5_sent", p_sent_n - ps, 1);

    // 6: link drops mid-TLP, then async reset mid-DATA
    do_reset();
    s = logq.size(); ps = p_sent_n;
    push(0, 10'd32, 32'h80);
    push(0, 10'd32, 32'h81);
    wait_p_pop("t6_first_pop");
    link_active_i = 1'b0;
    run(20);
    chk("t6_nhdr", n_req(s, REQ_P_HDR), 1);
    chk("t6_nbeats", n_req(s, REQ_P_DATA), 4);
    chk("t6_sent", p_sent_n - ps, 1);
    chk("t6_held", p_hdr_empty_i, 1'b0);
    chk("t6_idle", req_o, REQ_IDLE);
    link_active_i = 1'b1;
    wait_p_pop("t6_second_pop");
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_req", req_o, REQ_IDLE);
    chk("t6_rst_tlp", tlp_o[63:0], 64'd0);
    chk("t6_rst_rden", {p_hdr_rden_o, p_data_rden_o, p_sent_o}, 3'b000);
    chk("t6_rst_cc_pd", tx_cc_pd_o, 12'd0);

    // 7: PD consumed counter wraps 4094 + 4 -> 2 against limit 6
    do_reset();
    for (int i = 0; i < 15; i++) push(0, 10'd0, 32'h90 + i);
    push(0, 10'd1016, 32'h9F);
    run(2400);
    chk("t7_cc_pd_4094", tx_cc_pd_o, 12'd4094);
    chk("t7_cc_ph", tx_cc_ph_o, 12'd16);
    load_limits(12'd0, 12'd6);
    push(0, 10'd16, 32'hA0);
    run(12);
    chk("t7_wrap", tx_cc_pd_o, 12'd2);
    push(0, 10'd16, 32'hA1);
    run(12);
    chk("t7_at_limit", tx_cc_pd_o, 12'd6);
    push(0, 10'd16, 32'hA2);
    run(12);
    chk("t7_blocked_cc", tx_cc_pd_o, 12'd6);
    chk("t7_blocked_q", p_hdr_empty_i, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
